// File: rtl/alu_seq_pkg.sv
// Shared funct codes, FSM states and shift modes for the sequential MIPS ALU.
package alu_seq_pkg;

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_SLLV  = 6'b000100;
    localparam logic [5:0] F_SRLV  = 6'b000110;
    localparam logic [5:0] F_SRAV  = 6'b000111;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

    typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shift_mode_e;

    function automatic logic is_var_shift(input logic [5:0] f);
        return (f == F_SLLV) || (f == F_SRLV) || (f == F_SRAV);
    endfunction

    function automatic logic is_shift(input logic [5:0] f);
        return (f == F_SLL) || (f == F_SRL) || (f == F_SRA) || is_var_shift(f);
    endfunction

endpackage

// File: rtl/alu_seq_shifter.sv
// Iterative one-bit-per-cycle shift unit; also walks the multiplier bits for mult.
module alu_seq_shifter
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] din,
    input  logic [CW-1:0]    amount,
    input  shift_mode_e      mode,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] shifted_c,
    output logic             busy_c,
    output logic             done_c
);

    logic [CW-1:0] count;
    shift_mode_e   mode_q;

    // One-bit shift of the working register in the latched direction
    always_comb begin
        shifted_c = dout;
        case (mode_q)
            SH_LL:   shifted_c = {dout[WIDTH-2:0], 1'b0};
            SH_RL:   shifted_c = {1'b0, dout[WIDTH-1:1]};
            SH_RA:   shifted_c = {dout[WIDTH-1], dout[WIDTH-1:1]};
            default: shifted_c = dout;
        endcase
    end

    assign busy_c = (count != '0);
    // Final step is the one taken while count is 1 (or none at all for amount 0)
    assign done_c = (count <= CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout   <= '0;
            count  <= '0;
            mode_q <= SH_LL;
        end else if (load) begin
            dout   <= din;
            count  <= amount;
            mode_q <= mode;
        end else if (step && busy_c) begin
            dout  <= shifted_c;
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle MIPS R-type ALU with valid/ready handshakes and iterative shifts.
// Optional iterative mult/multu (and the hi port) enabled by ALU_SEQ_MULT_EN.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] ina,
    input  logic [WIDTH-1:0] inb,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             zero,
    output logic             illegal
`ifdef ALU_SEQ_MULT_EN
    ,
    output logic [WIDTH-1:0] hi
`endif
);

    localparam int unsigned CW  = SHW + 1;
    localparam int unsigned MSB = WIDTH - 1;

    state_e           state, state_next;
    logic [WIDTH-1:0] a_q, b_q;
    logic [5:0]       funct_q;
    logic             accept_c, fin_c, ov_c, ill_c;
    logic [WIDTH-1:0] res_c, sum_c, diff_c, hi_c;
    logic [WIDTH-1:0] sh_din_c, sh_dout, sh_shifted_c;
    logic [CW-1:0]    sh_amount_c;
    shift_mode_e      sh_mode_c;
    logic             sh_busy_c, sh_done_c;

    assign accept_c = in_valid && in_ready;
    assign sum_c    = a_q + b_q;
    assign diff_c   = a_q - b_q;

    // Shifter setup decoded from the live request; only consumed on accept
    always_comb begin
        sh_din_c    = inb;
        sh_amount_c = '0;
        sh_mode_c   = SH_RL;
        if (is_shift(funct)) begin
            sh_amount_c = is_var_shift(funct) ? CW'(ina[SHW-1:0]) : CW'(shamt);
        end
        case (funct)
            F_SLL, F_SLLV: sh_mode_c = SH_LL;
            F_SRA, F_SRAV: sh_mode_c = SH_RA;
            default:       sh_mode_c = SH_RL;
        endcase
`ifdef ALU_SEQ_MULT_EN
        if ((funct == F_MULT) || (funct == F_MULTU)) begin
            sh_amount_c = CW'(WIDTH);
            sh_din_c    = ((funct == F_MULT) && inb[MSB]) ? -inb : inb;
        end
`endif
    end

    alu_seq_shifter #(.WIDTH(WIDTH), .CW(CW)) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (accept_c),
        .step      (state == EXEC),
        .din       (sh_din_c),
        .amount    (sh_amount_c),
        .mode      (sh_mode_c),
        .dout      (sh_dout),
        .shifted_c (sh_shifted_c),
        .busy_c    (sh_busy_c),
        .done_c    (sh_done_c)
    );

`ifdef ALU_SEQ_MULT_EN
    // Shift-add on operand magnitudes; sign restored on the final product
    logic [2*WIDTH-1:0] acc, mcand, acc_next_c, prod_c;
    logic [WIDTH-1:0]   mag_a_c;
    logic               neg_q;

    assign mag_a_c    = ((funct == F_MULT) && ina[MSB]) ? -ina : ina;
    assign acc_next_c = acc + (sh_dout[0] ? mcand : '0);
    assign prod_c     = neg_q ? -acc_next_c : acc_next_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            mcand <= '0;
            neg_q <= 1'b0;
        end else if (accept_c) begin
            acc   <= '0;
            mcand <= {WIDTH'(0), mag_a_c};
            neg_q <= (funct == F_MULT) && (ina[MSB] ^ inb[MSB]);
        end else if (state == EXEC) begin
            acc   <= acc_next_c;
            mcand <= mcand << 1;
        end
    end
`endif

    // Result, flags and completion for the operation in flight
    always_comb begin
        res_c = '0;
        hi_c  = '0;
        ov_c  = 1'b0;
        ill_c = 1'b0;
        fin_c = 1'b1;
        case (funct_q)
            F_ADD: begin
                res_c = sum_c;
                ov_c  = (a_q[MSB] == b_q[MSB]) && (sum_c[MSB] != a_q[MSB]);
            end
            F_ADDU: res_c = sum_c;
            F_SUB: begin
                res_c = diff_c;
                ov_c  = (a_q[MSB] != b_q[MSB]) && (diff_c[MSB] != a_q[MSB]);
            end
            F_SUBU: res_c = diff_c;
            F_AND:  res_c = a_q & b_q;
            F_OR:   res_c = a_q | b_q;
            F_XOR:  res_c = a_q ^ b_q;
            F_NOR:  res_c = ~(a_q | b_q);
            F_SLT:  res_c = WIDTH'($signed(a_q) < $signed(b_q));
            F_SLTU: res_c = WIDTH'(a_q < b_q);
            F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV: begin
                res_c = sh_busy_c ? sh_shifted_c : sh_dout;
                fin_c = sh_done_c;
            end
`ifdef ALU_SEQ_MULT_EN
            F_MULT: begin
                res_c = prod_c[WIDTH-1:0];
                hi_c  = prod_c[2*WIDTH-1:WIDTH];
                ov_c  = prod_c[2*WIDTH-1:WIDTH] != {WIDTH{prod_c[MSB]}};
                fin_c = sh_done_c;
            end
            F_MULTU: begin
                res_c = prod_c[WIDTH-1:0];
                hi_c  = prod_c[2*WIDTH-1:WIDTH];
                ov_c  = prod_c[2*WIDTH-1:WIDTH] != '0;
                fin_c = sh_done_c;
            end
`endif
            default: ill_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_c) state_next = EXEC;
            EXEC:    if (fin_c) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake and result registers; result/flags move only on completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            zero      <= 1'b1;
            illegal   <= 1'b0;
`ifdef ALU_SEQ_MULT_EN
            hi        <= '0;
`endif
        end else begin
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
            if ((state == EXEC) && fin_c) begin
                result   <= res_c;
                overflow <= ov_c;
                zero     <= (res_c == '0);
                illegal  <= ill_c;
`ifdef ALU_SEQ_MULT_EN
                hi       <= hi_c;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            funct_q <= '0;
        end else if (accept_c) begin
            a_q     <= ina;
            b_q     <= inb;
            funct_q <= funct;
        end
    end

`ifndef ALU_SEQ_MULT_EN
    logic unused_hi;
    assign unused_hi = ^hi_c;
`endif

endmodule
